// File: rtl/pipeline_flush_ctrl.sv
// Pipeline flush/stall controller for an NSTAGE-deep in-order core.
// Stage 0 is fetch and stage NSTAGE-1 is CSR/commit.
//
// Ports:
//   clk_i, rst_ni            core clock, asynchronous active-low reset
//   xcpt_i, sys_jump_i       per-stage exception / sys-jump valids
//   itlb_xcpt_i              fetch TLB exception (status only)
//   branch_*_i, fencei_i     control-flow redirects resolved in exe
//   load_hazard_i            load-use hazard in dec
//   unsupported_i            unsupported instruction in dec
//   csr_flush_i              CSR write requiring a full refetch
//   sfence_*_i, rs1/rs2      SFENCE.VMA in mem plus its operands
//   tlb_flush_ack_i          MMU completion of a TLB flush
//   flush_o, stall_fe_o      per-stage flushes and front-end stall (combinational)
//   xcpt_valid_o             any exception present (combinational)
//   xcpt_after_o             bit s: exception in a stage above s (combinational)
//   sys_jump_after_o         bit s: sys-jump in a stage above s (combinational)
//   tlb_flush_*_o            TLB flush request and latched operands
//   tlb_timeout_o            one-cycle pulse when the MMU never acked
//   flush_cnt_o, hazard_cnt_o saturating performance counters
module pipeline_flush_ctrl #(
  parameter int unsigned NSTAGE = 6,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ASID_W = 16,
  parameter int unsigned BPU_EN = 1,
  parameter int unsigned TLB_TO = 255,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NSTAGE-1:0] xcpt_i,
  input  logic [NSTAGE-1:0] sys_jump_i,
  input  logic              itlb_xcpt_i,
  input  logic              branch_taken_i,
  input  logic              branch_hit_i,
  input  logic              branch_mispred_i,
  input  logic              fencei_i,
  input  logic              load_hazard_i,
  input  logic              unsupported_i,
  input  logic              csr_flush_i,
  input  logic              sfence_i,
  input  logic              sfence_type_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              tlb_flush_ack_i,
  output logic [NSTAGE-1:0] flush_o,
  output logic              stall_fe_o,
  output logic              xcpt_valid_o,
  output logic [NSTAGE-1:0] xcpt_after_o,
  output logic [NSTAGE-1:0] sys_jump_after_o,
  output logic              tlb_flush_req_o,
  output logic              tlb_flush_type_o,
  output logic [XLEN-1:0]   tlb_flush_vaddr_o,
  output logic [ASID_W-1:0] tlb_flush_asid_o,
  output logic              tlb_timeout_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  hazard_cnt_o
);

  localparam int unsigned TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TLB_TO);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               type_q, type_d;
  logic [XLEN-1:0]    vaddr_q, vaddr_d;
  logic [ASID_W-1:0]  asid_q, asid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   hazard_cnt_q, hazard_cnt_d;

  logic [NSTAGE-1:0]  ev;
  logic [NSTAGE-1:0]  ev_after;
  logic [NSTAGE-1:0]  xcpt_after;
  logic [NSTAGE-1:0]  sj_after;
  logic [NSTAGE-1:0]  flush_c;
  logic               branch_flush;
  logic               older_kill;
  logic               sfence_acc;
  logic               busy;

  assign ev   = xcpt_i | sys_jump_i;
  assign busy = (state_q != IDLE);

  // Bit s is set when any strictly younger-indexed (later) stage has the event.
  for (genvar s = 0; s < NSTAGE; s++) begin : g_after
    assign xcpt_after[s] = |(xcpt_i >> (s + 1));
    assign sj_after[s]   = |(sys_jump_i >> (s + 1));
    assign ev_after[s]   = |(ev >> (s + 1));
  end

  // An event beyond mem belongs to an older instruction and kills the sfence.
  assign older_kill = |(ev >> 4);
  assign sfence_acc = sfence_i & ~older_kill & ~busy;

  // Per-stage flush: OR of every reason that covers that stage.
  always_comb begin
    flush_c      = ev_after;
    branch_flush = (BPU_EN != 0) ? ((branch_taken_i & ~branch_hit_i) | branch_mispred_i)
                                 : branch_taken_i;
    if (branch_flush) begin
      flush_c[1:0] = 2'b11;
    end
    if (fencei_i || sfence_acc) begin
      flush_c[2:0] = 3'b111;
    end
    // Hazards and the TLB wait both inject bubbles into dec.
    if (load_hazard_i || unsupported_i || busy) begin
      flush_c[1] = 1'b1;
    end
    if (csr_flush_i) begin
      flush_c[NSTAGE-2:0] = '1;
    end
  end

  // SFENCE.VMA request/ack sequencing with timeout.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    type_d    = type_q;
    vaddr_d   = vaddr_q;
    asid_d    = asid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sfence_acc) begin
          state_d   = REQ;
          tmo_cnt_d = '0;
          type_d    = sfence_type_i;
          vaddr_d   = rs1_data_i;
          asid_d    = rs2_data_i[ASID_W-1:0];
        end
      end
      REQ: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tlb_flush_ack_i) begin
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    hazard_cnt_d = hazard_cnt_q;
    if (flush_c[0] && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (load_hazard_i && (hazard_cnt_q != '1)) begin
      hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      type_q       <= 1'b0;
      vaddr_q      <= '0;
      asid_q       <= '0;
      timeout_q    <= 1'b0;
      flush_cnt_q  <= '0;
      hazard_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      type_q       <= type_d;
      vaddr_q      <= vaddr_d;
      asid_q       <= asid_d;
      timeout_q    <= timeout_d;
      flush_cnt_q  <= flush_cnt_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  // Upper rs2 bits carry no ASID information.
  if (XLEN > ASID_W) begin : g_rs2_hi
    logic unused_rs2_hi;
    assign unused_rs2_hi = ^rs2_data_i[XLEN-1:ASID_W];
  end

  assign flush_o           = flush_c;
  assign stall_fe_o        = load_hazard_i | busy;
  assign xcpt_valid_o      = (|xcpt_i) | itlb_xcpt_i;
  assign xcpt_after_o      = xcpt_after;
  assign sys_jump_after_o  = sj_after;
  assign tlb_flush_req_o   = (state_q == REQ);
  assign tlb_flush_type_o  = type_q;
  assign tlb_flush_vaddr_o = vaddr_q;
  assign tlb_flush_asid_o  = asid_q;
  assign tlb_timeout_o     = timeout_q;
  assign flush_cnt_o       = flush_cnt_q;
  assign hazard_cnt_o      = hazard_cnt_q;

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Self-checking bench for pipeline_flush_ctrl: directed scenarios plus a
// randomized run compared against a rule-level reference model.
module tb_pipeline_flush_ctrl;

  localparam int N      = 6;
  localparam int XLEN   = 64;
  localparam int ASID_W = 16;
  localparam int TLB_TO = 255;
  localparam int CNT_W  = 10;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_i;
  logic              rst_ni;
  logic [N-1:0]      xcpt_i, sys_jump_i;
  logic              itlb_xcpt_i, branch_taken_i, branch_hit_i, branch_mispred_i;
  logic              fencei_i, load_hazard_i, unsupported_i, csr_flush_i;
  logic              sfence_i, sfence_type_i, tlb_flush_ack_i;
  logic [XLEN-1:0]   rs1_data_i, rs2_data_i;
  logic [N-1:0]      flush_o, xcpt_after_o, sys_jump_after_o;
  logic              stall_fe_o, xcpt_valid_o, tlb_flush_req_o, tlb_flush_type_o, tlb_timeout_o;
  logic [XLEN-1:0]   tlb_flush_vaddr_o;
  logic [ASID_W-1:0] tlb_flush_asid_o;
  logic [CNT_W-1:0]  flush_cnt_o, hazard_cnt_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit                m_req;
  int                m_cycles;
  bit                m_type;
  logic [XLEN-1:0]   m_vaddr;
  logic [ASID_W-1:0] m_asid;
  bit                m_to;
  int                m_fcnt, m_hcnt;

  pipeline_flush_ctrl #(
    .NSTAGE(N), .XLEN(XLEN), .ASID_W(ASID_W), .BPU_EN(1), .TLB_TO(TLB_TO), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .xcpt_i(xcpt_i), .sys_jump_i(sys_jump_i),
    .itlb_xcpt_i(itlb_xcpt_i), .branch_taken_i(branch_taken_i), .branch_hit_i(branch_hit_i),
    .branch_mispred_i(branch_mispred_i), .fencei_i(fencei_i), .load_hazard_i(load_hazard_i),
    .unsupported_i(unsupported_i), .csr_flush_i(csr_flush_i), .sfence_i(sfence_i),
    .sfence_type_i(sfence_type_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .tlb_flush_ack_i(tlb_flush_ack_i), .flush_o(flush_o), .stall_fe_o(stall_fe_o),
    .xcpt_valid_o(xcpt_valid_o), .xcpt_after_o(xcpt_after_o),
    .sys_jump_after_o(sys_jump_after_o), .tlb_flush_req_o(tlb_flush_req_o),
    .tlb_flush_type_o(tlb_flush_type_o), .tlb_flush_vaddr_o(tlb_flush_vaddr_o),
    .tlb_flush_asid_o(tlb_flush_asid_o), .tlb_timeout_o(tlb_timeout_o),
    .flush_cnt_o(flush_cnt_o), .hazard_cnt_o(hazard_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // An sfence is taken only when idle and no stage from 4 upward has an event.
  function automatic bit exp_sacc();
    if (!sfence_i || m_req) return 1'b0;
    for (int k = 4; k < N; k++) begin
      if (xcpt_i[k] || sys_jump_i[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] after_of(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int s = 0; s < N; s++) begin
      for (int k = s + 1; k < N; k++) begin
        if (v[k]) r[s] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_flush();
    logic [N-1:0] f;
    bit br, sacc;
    f    = '0;
    br   = branch_mispred_i || (branch_taken_i && !branch_hit_i);
    sacc = exp_sacc();
    for (int s = 0; s < N; s++) begin
      for (int k = s + 1; k < N; k++) begin
        if (xcpt_i[k] || sys_jump_i[k]) f[s] = 1'b1;
      end
      if (s <= 1 && br) f[s] = 1'b1;
      if (s <= 2 && (fencei_i || sacc)) f[s] = 1'b1;
      if (s == 1 && (load_hazard_i || unsupported_i || m_req)) f[s] = 1'b1;
      if (s <= N - 2 && csr_flush_i) f[s] = 1'b1;
    end
    return f;
  endfunction

  task automatic clear_inputs();
    xcpt_i = '0; sys_jump_i = '0; itlb_xcpt_i = 0; branch_taken_i = 0; branch_hit_i = 0;
    branch_mispred_i = 0; fencei_i = 0; load_hazard_i = 0; unsupported_i = 0;
    csr_flush_i = 0; sfence_i = 0; sfence_type_i = 0; rs1_data_i = '0; rs2_data_i = '0;
    tlb_flush_ack_i = 0;
  endtask

  task automatic model_reset();
    m_req = 0; m_cycles = 0; m_type = 0; m_vaddr = '0; m_asid = '0; m_to = 0;
    m_fcnt = 0; m_hcnt = 0;
  endtask

  // Advance the model with the current inputs, then let one clock edge pass.
  task automatic tick();
    logic [N-1:0] f;
    bit sacc, to_n;
    f    = exp_flush();
    sacc = exp_sacc();
    to_n = 0;
    if (m_req) begin
      m_cycles++;
      if (tlb_flush_ack_i) m_req = 0;
      else if (m_cycles == TLB_TO + 1) begin
        m_req = 0;
        to_n  = 1;
      end
    end else if (sacc) begin
      m_req = 1; m_cycles = 0; m_type = sfence_type_i;
      m_vaddr = rs1_data_i; m_asid = rs2_data_i[ASID_W-1:0];
    end
    m_to = to_n;
    if (f[0] && m_fcnt < CMAX) m_fcnt++;
    if (load_hazard_i && m_hcnt < CMAX) m_hcnt++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    xcpt_i = 6'b001000;
    #2;
    total++; if (flush_o !== 6'b000111) begin bad++; $display("FAIL rst_comb_flush got=%b want=000111", flush_o); end
    @(posedge clk_i); #1;
    total++; if (tlb_flush_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", tlb_flush_req_o); end
    total++; if (tlb_timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", tlb_timeout_o); end
    total++; if (flush_cnt_o !== '0 || hazard_cnt_o !== '0) begin bad++; $display("FAIL rst_counters got=%0d/%0d want=0/0", flush_cnt_o, hazard_cnt_o); end
    total++; if (tlb_flush_vaddr_o !== '0 || tlb_flush_asid_o !== '0 || tlb_flush_type_o !== 1'b0) begin bad++; $display("FAIL rst_operands got=%h/%h/%b want=0", tlb_flush_vaddr_o, tlb_flush_asid_o, tlb_flush_type_o); end
    clear_inputs();
  endtask

  task automatic test_xcpt();
    clear_inputs(); xcpt_i = 6'b001000; #1;
    total++; if (flush_o !== 6'b000111) begin bad++; $display("FAIL xcpt_mem_flush got=%b want=000111", flush_o); end
    total++; if (xcpt_after_o !== 6'b000111) begin bad++; $display("FAIL xcpt_mem_after got=%b want=000111", xcpt_after_o); end
    total++; if (xcpt_valid_o !== 1'b1) begin bad++; $display("FAIL xcpt_mem_valid got=%b want=1", xcpt_valid_o); end
    tick();
    clear_inputs(); sys_jump_i = 6'b010000; #1;
    total++; if (flush_o !== 6'b001111) begin bad++; $display("FAIL sysjump_flush got=%b want=001111", flush_o); end
    total++; if (sys_jump_after_o !== 6'b001111) begin bad++; $display("FAIL sysjump_after got=%b want=001111", sys_jump_after_o); end
    total++; if (xcpt_valid_o !== 1'b0) begin bad++; $display("FAIL sysjump_valid got=%b want=0", xcpt_valid_o); end
    tick();
    clear_inputs(); itlb_xcpt_i = 1; #1;
    total++; if (xcpt_valid_o !== 1'b1 || flush_o !== '0) begin bad++; $display("FAIL itlb got valid=%b flush=%b want 1/000000", xcpt_valid_o, flush_o); end
    tick();
  endtask

  task automatic test_branch();
    // pattern bits: 0 taken, 1 hit, 2 mispred, 3 fencei, 4 csr_flush, 5 unsupported
    logic [5:0] pat [6] = '{6'b000011, 6'b000100, 6'b000001, 6'b001000, 6'b010000, 6'b100000};
    logic [5:0] exp [6] = '{6'b000000, 6'b000011, 6'b000011, 6'b000111, 6'b011111, 6'b000010};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      branch_taken_i = pat[i][0]; branch_hit_i = pat[i][1]; branch_mispred_i = pat[i][2];
      fencei_i = pat[i][3]; csr_flush_i = pat[i][4]; unsupported_i = pat[i][5];
      #1;
      total++; if (flush_o !== exp[i]) begin bad++; $display("FAIL branch_pat%0d got=%b want=%b", i, flush_o, exp[i]); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_load_hazard();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_hazard_i = 1; #1;
      total++; if (flush_o !== 6'b000010 || stall_fe_o !== 1'b1) begin bad++; $display("FAIL hazard_cyc%0d got flush=%b stall=%b want 000010/1", i, flush_o, stall_fe_o); end
      tick();
    end
    load_hazard_i = 0; #1;
    total++; if (hazard_cnt_o !== CNT_W'(3)) begin bad++; $display("FAIL hazard_cnt got=%0d want=3", hazard_cnt_o); end
    total++; if (flush_cnt_o !== '0) begin bad++; $display("FAIL hazard_flush_cnt got=%0d want=0", flush_cnt_o); end
    tick();
  endtask

  task automatic test_sfence_ack();
    clear_inputs();
    sfence_i = 1; sfence_type_i = 1; rs1_data_i = 64'h8000_1000; rs2_data_i = 64'd5; #1;
    total++; if (flush_o !== 6'b000111 || tlb_flush_req_o !== 1'b0) begin bad++; $display("FAIL sfence_accept got flush=%b req=%b want 000111/0", flush_o, tlb_flush_req_o); end
    tick();
    sfence_i = 0; sfence_type_i = 0; rs1_data_i = 64'hFFFF_0000_1234_5678; rs2_data_i = 64'h77; #1;
    total++; if (tlb_flush_req_o !== 1'b1 || stall_fe_o !== 1'b1 || flush_o !== 6'b000010) begin bad++; $display("FAIL sfence_req got req=%b stall=%b flush=%b want 1/1/000010", tlb_flush_req_o, stall_fe_o, flush_o); end
    total++; if (tlb_flush_vaddr_o !== 64'h8000_1000 || tlb_flush_asid_o !== 16'd5 || tlb_flush_type_o !== 1'b1) begin bad++; $display("FAIL sfence_latch got %h/%h/%b want 80001000/0005/1", tlb_flush_vaddr_o, tlb_flush_asid_o, tlb_flush_type_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (tlb_flush_req_o !== 1'b1 || tlb_flush_vaddr_o !== 64'h8000_1000) begin bad++; $display("FAIL sfence_hold%0d got req=%b vaddr=%h want 1/80001000", i, tlb_flush_req_o, tlb_flush_vaddr_o); end
    end
    tlb_flush_ack_i = 1; #1;
    tick();
    tlb_flush_ack_i = 0; #1;
    total++; if (tlb_flush_req_o !== 1'b0 || stall_fe_o !== 1'b0 || tlb_timeout_o !== 1'b0) begin bad++; $display("FAIL sfence_done got req=%b stall=%b to=%b want 0/0/0", tlb_flush_req_o, stall_fe_o, tlb_timeout_o); end
    tlb_flush_ack_i = 1; #1;
    tick();
    tlb_flush_ack_i = 0; #1;
    total++; if (tlb_flush_req_o !== 1'b0) begin bad++; $display("FAIL idle_ack got req=%b want 0", tlb_flush_req_o); end
    clear_inputs();
  endtask

  task automatic test_sfence_killed();
    clear_inputs(); sfence_i = 1; xcpt_i = 6'b100000; rs1_data_i = 64'h1234; #1;
    total++; if (flush_o !== 6'b011111) begin bad++; $display("FAIL sfence_kill_flush got=%b want=011111", flush_o); end
    tick();
    clear_inputs(); #1;
    total++; if (tlb_flush_req_o !== 1'b0) begin bad++; $display("FAIL sfence_kill_req got=%b want 0", tlb_flush_req_o); end
    sfence_i = 1; sys_jump_i = 6'b010000; #1;
    total++; if (flush_o !== 6'b001111) begin bad++; $display("FAIL sfence_kill_sj_flush got=%b want=001111", flush_o); end
    tick();
    clear_inputs(); #1;
    total++; if (tlb_flush_req_o !== 1'b0) begin bad++; $display("FAIL sfence_kill_sj_req got=%b want 0", tlb_flush_req_o); end
  endtask

  task automatic test_timeout();
    int n;
    clear_inputs(); sfence_i = 1; rs1_data_i = 64'hABCD_0000; rs2_data_i = 64'h9; #1;
    tick();
    clear_inputs();
    n = 0;
    while (tlb_flush_req_o === 1'b1 && n < 400) begin
      n++;
      sfence_i = (n == 10);
      rs1_data_i = (n == 10) ? 64'h5555_5555 : 64'h0;
      #1;
      if (n == 10) begin
        total++; if (flush_o !== 6'b000010) begin bad++; $display("FAIL sfence_in_req_flush got=%b want=000010", flush_o); end
      end
      tick();
    end
    clear_inputs(); #1;
    total++; if (n !== TLB_TO + 1) begin bad++; $display("FAIL timeout_len got=%0d want=%0d", n, TLB_TO + 1); end
    total++; if (tlb_timeout_o !== 1'b1 || tlb_flush_req_o !== 1'b0) begin bad++; $display("FAIL timeout_pulse got to=%b req=%b want 1/0", tlb_timeout_o, tlb_flush_req_o); end
    total++; if (tlb_flush_vaddr_o !== 64'hABCD_0000) begin bad++; $display("FAIL timeout_vaddr got=%h want=abcd0000", tlb_flush_vaddr_o); end
    tick();
    total++; if (tlb_timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_one_cycle got=%b want 0", tlb_timeout_o); end
  endtask

  task automatic test_reset_mid_req();
    clear_inputs(); sfence_i = 1; rs1_data_i = 64'h42; #1;
    tick();
    clear_inputs(); #1;
    total++; if (tlb_flush_req_o !== 1'b1) begin bad++; $display("FAIL midreq_pre got=%b want 1", tlb_flush_req_o); end
    #1 rst_ni = 1'b0;
    #1;
    total++; if (tlb_flush_req_o !== 1'b0 || tlb_flush_vaddr_o !== '0) begin bad++; $display("FAIL midreq_async got req=%b vaddr=%h want 0/0", tlb_flush_req_o, tlb_flush_vaddr_o); end
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic [N-1:0] ef;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        xcpt_i[k]     = ($urandom_range(0, 9) == 0);
        sys_jump_i[k] = ($urandom_range(0, 9) == 0);
      end
      itlb_xcpt_i      = ($urandom_range(0, 7) == 0);
      branch_taken_i   = ($urandom_range(0, 3) == 0);
      branch_hit_i     = ($urandom_range(0, 1) == 0);
      branch_mispred_i = ($urandom_range(0, 7) == 0);
      fencei_i         = ($urandom_range(0, 9) == 0);
      load_hazard_i    = ($urandom_range(0, 1) == 0);
      unsupported_i    = ($urandom_range(0, 9) == 0);
      csr_flush_i      = ($urandom_range(0, 11) == 0);
      sfence_i         = ($urandom_range(0, 3) == 0);
      sfence_type_i    = 1'($urandom);
      rs1_data_i       = {$urandom, $urandom};
      rs2_data_i       = {$urandom, $urandom};
      tlb_flush_ack_i  = ($urandom_range(0, 15) == 0);
      #1;
      ef = exp_flush();
      total++; if (flush_o !== ef) begin bad++; $display("FAIL rnd_flush c=%0d got=%b want=%b", c, flush_o, ef); end
      total++; if (stall_fe_o !== (load_hazard_i | m_req)) begin bad++; $display("FAIL rnd_stall c=%0d got=%b want=%b", c, stall_fe_o, load_hazard_i | m_req); end
      total++; if (xcpt_valid_o !== ((|xcpt_i) | itlb_xcpt_i)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b", c, xcpt_valid_o); end
      total++; if (xcpt_after_o !== after_of(xcpt_i) || sys_jump_after_o !== after_of(sys_jump_i)) begin bad++; $display("FAIL rnd_after c=%0d got=%b/%b want=%b/%b", c, xcpt_after_o, sys_jump_after_o, after_of(xcpt_i), after_of(sys_jump_i)); end
      total++; if (tlb_flush_req_o !== m_req || tlb_timeout_o !== m_to) begin bad++; $display("FAIL rnd_req c=%0d got=%b/%b want=%b/%b", c, tlb_flush_req_o, tlb_timeout_o, m_req, m_to); end
      total++; if (tlb_flush_vaddr_o !== m_vaddr || tlb_flush_asid_o !== m_asid || tlb_flush_type_o !== m_type) begin bad++; $display("FAIL rnd_ops c=%0d got=%h/%h/%b want=%h/%h/%b", c, tlb_flush_vaddr_o, tlb_flush_asid_o, tlb_flush_type_o, m_vaddr, m_asid, m_type); end
      total++; if (flush_cnt_o !== CNT_W'(m_fcnt) || hazard_cnt_o !== CNT_W'(m_hcnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d want=%0d/%0d", c, flush_cnt_o, hazard_cnt_o, m_fcnt, m_hcnt); end
      tick();
    end
    clear_inputs(); #1;
    total++; if (flush_cnt_o !== CNT_W'(CMAX)) begin bad++; $display("FAIL rnd_flush_cnt_sat got=%0d want=%0d", flush_cnt_o, CMAX); end
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    do_reset();
    test_xcpt();
    test_branch();
    test_load_hazard();
    test_sfence_ack();
    test_sfence_killed();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
